dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data RAM between the MEM stage and a DMA
//            port, one fixed-latency access in flight at a time.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int RD_LAT   = 1,
    parameter int CPU_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [31:0]       cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    input  logic [3:0]        cpu_req_wstrb,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [31:0]       cpu_rsp_rdata,
    output logic              hold_flag_mem,

    input  logic              dma_req_valid,
    input  logic              dma_req_we,
    input  logic [31:0]       dma_req_addr,
    input  logic [31:0]       dma_req_wdata,
    input  logic [3:0]        dma_req_wstrb,
    output logic              dma_req_ready,
    output logic              dma_rsp_valid,
    output logic [31:0]       dma_rsp_rdata,

    output logic              dram_en,
    output logic [3:0]        dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [31:0]       dram_wdi,
    input  logic [31:0]       dram_rdo
);

    localparam int                 c_LAT_W   = $clog2(RD_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_MAX = c_LAT_W'(RD_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE = c_LAT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_owner;
    logic                 r_last_grant;
    logic                 r_is_wr;
    logic [c_LAT_W-1:0]   r_lat_cnt;

    logic                 w_any_req;
    logic                 w_pick_dma;
    logic                 w_accept;
    logic                 w_lat_done;
    logic                 w_sel_we;
    logic [31:0]          w_sel_addr;
    logic [31:0]          w_sel_wdata;
    logic [3:0]           w_sel_wstrb;
    logic                 w_unused_addr_bits;

    assign w_any_req = cpu_req_valid | dma_req_valid;

    // Round-robin tie goes to the port that did not win last time.
    generate
        if (CPU_PRIO != 0) begin : g_cpu_prio
            assign w_pick_dma = ~cpu_req_valid;
        end else begin : g_round_robin
            assign w_pick_dma = dma_req_valid & (~cpu_req_valid | ~r_last_grant);
        end
    endgenerate

    assign w_accept   = (r_state == S_IDLE) & w_any_req & ~rst;
    assign w_lat_done = (r_lat_cnt == c_LAT_MAX);

    assign w_sel_we    = w_pick_dma ? dma_req_we    : cpu_req_we;
    assign w_sel_addr  = w_pick_dma ? dma_req_addr  : cpu_req_addr;
    assign w_sel_wdata = w_pick_dma ? dma_req_wdata : cpu_req_wdata;
    assign w_sel_wstrb = w_pick_dma ? dma_req_wstrb : cpu_req_wstrb;

    assign w_unused_addr_bits = ^{w_sel_addr[1:0], w_sel_addr[31:ADDR_W+2]};

    always_comb begin
        w_state_nxt   = r_state;
        cpu_req_ready = 1'b0;
        dma_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        dma_rsp_valid = 1'b0;
        cpu_rsp_rdata = 32'h0;
        dma_rsp_rdata = 32'h0;
        dram_en       = 1'b0;
        dram_we       = 4'b0000;
        dram_addr     = '0;
        dram_wdi      = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_BUSY;
                    cpu_req_ready = ~w_pick_dma;
                    dma_req_ready = w_pick_dma;
                    dram_en       = 1'b1;
                    dram_we       = w_sel_we ? w_sel_wstrb : 4'b0000;
                    dram_addr     = w_sel_addr[ADDR_W+1:2];
                    dram_wdi      = w_sel_wdata;
                end
            end
            S_BUSY: begin
                if (w_lat_done) begin
                    w_state_nxt = S_IDLE;
                    // A reset landing in the response cycle drops the pulse.
                    if (!rst) begin
                        if (r_owner) begin
                            dma_rsp_valid = 1'b1;
                            dma_rsp_rdata = r_is_wr ? 32'h0 : dram_rdo;
                        end else begin
                            cpu_rsp_valid = 1'b1;
                            cpu_rsp_rdata = r_is_wr ? 32'h0 : dram_rdo;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign hold_flag_mem = cpu_req_valid & ~cpu_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_is_wr      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_pick_dma;
                r_last_grant <= w_pick_dma;
                r_is_wr      <= w_sel_we;
                r_lat_cnt    <= c_LAT_ONE;
            end else if (r_state == S_BUSY) begin
                if (w_lat_done) begin
                    r_lat_cnt <= '0;
                end else begin
                    r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter: round-robin RD_LAT=1 instance
//            and CPU-priority RD_LAT=3 instance, each with a behavioural RAM.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [31:0] c_JUNK = 32'h5A5A_5A5A;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    exp_t q_acpu[$];
    exp_t q_adma[$];
    exp_t q_bcpu[$];
    exp_t q_bdma[$];

    // Instance A: RD_LAT=1, round robin
    logic        a_cpu_req_valid, a_cpu_req_we, a_cpu_req_ready, a_cpu_rsp_valid, a_hold;
    logic [31:0] a_cpu_req_addr, a_cpu_req_wdata, a_cpu_rsp_rdata;
    logic [3:0]  a_cpu_req_wstrb;
    logic        a_dma_req_valid, a_dma_req_we, a_dma_req_ready, a_dma_rsp_valid;
    logic [31:0] a_dma_req_addr, a_dma_req_wdata, a_dma_rsp_rdata;
    logic [3:0]  a_dma_req_wstrb;
    logic        a_dram_en;
    logic [3:0]  a_dram_we;
    logic [13:0] a_dram_addr;
    logic [31:0] a_dram_wdi, a_dram_rdo;

    // Instance B: RD_LAT=3, CPU priority
    logic        b_cpu_req_valid, b_cpu_req_we, b_cpu_req_ready, b_cpu_rsp_valid, b_hold;
    logic [31:0] b_cpu_req_addr, b_cpu_req_wdata, b_cpu_rsp_rdata;
    logic [3:0]  b_cpu_req_wstrb;
    logic        b_dma_req_valid, b_dma_req_we, b_dma_req_ready, b_dma_rsp_valid;
    logic [31:0] b_dma_req_addr, b_dma_req_wdata, b_dma_rsp_rdata;
    logic [3:0]  b_dma_req_wstrb;
    logic        b_dram_en;
    logic [3:0]  b_dram_we;
    logic [13:0] b_dram_addr;
    logic [31:0] b_dram_wdi, b_dram_rdo;

    dmem_arbiter #(.ADDR_W(14), .RD_LAT(1), .CPU_PRIO(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_req_valid(a_cpu_req_valid), .cpu_req_we(a_cpu_req_we),
        .cpu_req_addr(a_cpu_req_addr), .cpu_req_wdata(a_cpu_req_wdata),
        .cpu_req_wstrb(a_cpu_req_wstrb), .cpu_req_ready(a_cpu_req_ready),
        .cpu_rsp_valid(a_cpu_rsp_valid), .cpu_rsp_rdata(a_cpu_rsp_rdata),
        .hold_flag_mem(a_hold),
        .dma_req_valid(a_dma_req_valid), .dma_req_we(a_dma_req_we),
        .dma_req_addr(a_dma_req_addr), .dma_req_wdata(a_dma_req_wdata),
        .dma_req_wstrb(a_dma_req_wstrb), .dma_req_ready(a_dma_req_ready),
        .dma_rsp_valid(a_dma_rsp_valid), .dma_rsp_rdata(a_dma_rsp_rdata),
        .dram_en(a_dram_en), .dram_we(a_dram_we), .dram_addr(a_dram_addr),
        .dram_wdi(a_dram_wdi), .dram_rdo(a_dram_rdo)
    );

    dmem_arbiter #(.ADDR_W(14), .RD_LAT(3), .CPU_PRIO(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_req_valid(b_cpu_req_valid), .cpu_req_we(b_cpu_req_we),
        .cpu_req_addr(b_cpu_req_addr), .cpu_req_wdata(b_cpu_req_wdata),
        .cpu_req_wstrb(b_cpu_req_wstrb), .cpu_req_ready(b_cpu_req_ready),
        .cpu_rsp_valid(b_cpu_rsp_valid), .cpu_rsp_rdata(b_cpu_rsp_rdata),
        .hold_flag_mem(b_hold),
        .dma_req_valid(b_dma_req_valid), .dma_req_we(b_dma_req_we),
        .dma_req_addr(b_dma_req_addr), .dma_req_wdata(b_dma_req_wdata),
        .dma_req_wstrb(b_dma_req_wstrb), .dma_req_ready(b_dma_req_ready),
        .dma_rsp_valid(b_dma_rsp_valid), .dma_rsp_rdata(b_dma_rsp_rdata),
        .dram_en(b_dram_en), .dram_we(b_dram_we), .dram_addr(b_dram_addr),
        .dram_wdi(b_dram_wdi), .dram_rdo(b_dram_rdo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAMs: word i holds 0x1000_0000+i, word 4 holds 0xDEAD_BEEF.
    // Read data appears RD_LAT cycles after the command, junk otherwise.
    logic [31:0] a_mem [0:255];
    logic [31:0] b_mem [0:255];
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [0:2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) a_mem[i] <= 32'h1000_0000 + 32'(i);
            a_mem[4] <= 32'hDEAD_BEEF;
        end else if (a_dram_en) begin
            for (int b = 0; b < 4; b++)
                if (a_dram_we[b]) a_mem[a_dram_addr[7:0]][8*b +: 8] <= a_dram_wdi[8*b +: 8];
        end
        a_pipe <= a_dram_en ? a_mem[a_dram_addr[7:0]] : c_JUNK;
    end
    assign a_dram_rdo = a_pipe;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= 32'h1000_0000 + 32'(i);
            b_mem[4] <= 32'hDEAD_BEEF;
        end else if (b_dram_en) begin
            for (int b = 0; b < 4; b++)
                if (b_dram_we[b]) b_mem[b_dram_addr[7:0]][8*b +: 8] <= b_dram_wdi[8*b +: 8];
        end
        b_pipe[0] <= b_dram_en ? b_mem[b_dram_addr[7:0]] : c_JUNK;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_dram_rdo = b_pipe[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic rsp_chk(input string nm, input int sz, input exp_t e, input logic [31:0] rd);
        if (sz == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got unexpected response %h at cycle %0d, expected none", nm, rd, cyc);
        end else begin
            chk({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
            chk({nm, "_rdata"}, rd, e.data);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        int   sz;
        if (a_cpu_rsp_valid) begin
            sz = q_acpu.size(); e = '{0, 32'h0};
            if (sz > 0) e = q_acpu.pop_front();
            rsp_chk("a_cpu_rsp", sz, e, a_cpu_rsp_rdata);
        end
        if (a_dma_rsp_valid) begin
            sz = q_adma.size(); e = '{0, 32'h0};
            if (sz > 0) e = q_adma.pop_front();
            rsp_chk("a_dma_rsp", sz, e, a_dma_rsp_rdata);
        end
        if (b_cpu_rsp_valid) begin
            sz = q_bcpu.size(); e = '{0, 32'h0};
            if (sz > 0) e = q_bcpu.pop_front();
            rsp_chk("b_cpu_rsp", sz, e, b_cpu_rsp_rdata);
        end
        if (b_dma_rsp_valid) begin
            sz = q_bdma.size(); e = '{0, 32'h0};
            if (sz > 0) e = q_bdma.pop_front();
            rsp_chk("b_dma_rsp", sz, e, b_dma_rsp_rdata);
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic a_cpu(input logic v, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] st);
        a_cpu_req_valid = v; a_cpu_req_we = we; a_cpu_req_addr = ad;
        a_cpu_req_wdata = wd; a_cpu_req_wstrb = st;
    endtask

    task automatic a_dma(input logic v, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] st);
        a_dma_req_valid = v; a_dma_req_we = we; a_dma_req_addr = ad;
        a_dma_req_wdata = wd; a_dma_req_wstrb = st;
    endtask

    task automatic b_cpu(input logic v, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] st);
        b_cpu_req_valid = v; b_cpu_req_we = we; b_cpu_req_addr = ad;
        b_cpu_req_wdata = wd; b_cpu_req_wstrb = st;
    endtask

    task automatic b_dma(input logic v, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] st);
        b_dma_req_valid = v; b_dma_req_we = we; b_dma_req_addr = ad;
        b_dma_req_wdata = wd; b_dma_req_wstrb = st;
    endtask

    initial begin
        int t;
        a_cpu(0, 0, 0, 0, 0); a_dma(0, 0, 0, 0, 0);
        b_cpu(0, 0, 0, 0, 0); b_dma(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) nxt;

        // ---------- reset overrides acceptance ----------
        a_cpu(1, 0, 32'h10, 0, 4'hF); a_dma(1, 0, 32'h14, 0, 4'hF);
        smp;
        chk("rst_a_cpu_ready", 32'(a_cpu_req_ready), 0);
        chk("rst_a_dma_ready", 32'(a_dma_req_ready), 0);
        chk("rst_a_dram_en",   32'(a_dram_en), 0);
        chk("rst_a_hold",      32'(a_hold), 1);

        // ---------- A: tie right after reset, CPU first then DMA ----------
        nxt; rst = 1'b0; t = cyc;
        smp;
        chk("tie1_cpu_ready", 32'(a_cpu_req_ready), 1);
        chk("tie1_dma_ready", 32'(a_dma_req_ready), 0);
        chk("tie1_dram_en",   32'(a_dram_en), 1);
        chk("tie1_dram_addr", 32'(a_dram_addr), 4);
        chk("tie1_dram_we",   32'(a_dram_we), 0);
        chk("tie1_hold",      32'(a_hold), 1);
        q_acpu.push_back('{t + 1, 32'hDEAD_BEEF});
        nxt; smp;
        chk("busy_cpu_ready", 32'(a_cpu_req_ready), 0);
        chk("busy_dma_ready", 32'(a_dma_req_ready), 0);
        chk("busy_dram_en",   32'(a_dram_en), 0);
        chk("rsp_hold_drop",  32'(a_hold), 0);
        nxt; a_cpu(1, 0, 32'h18, 0, 4'hF);
        smp;
        chk("tie2_dma_ready", 32'(a_dma_req_ready), 1);
        chk("tie2_cpu_ready", 32'(a_cpu_req_ready), 0);
        chk("tie2_dram_addr", 32'(a_dram_addr), 5);
        chk("tie2_hold",      32'(a_hold), 1);
        q_adma.push_back('{t + 3, 32'h1000_0005});
        nxt; smp;
        chk("dma_own_hold",      32'(a_hold), 1);
        chk("nonowner_cpu_rd",   a_cpu_rsp_rdata, 0);
        chk("dma_rsp_cpu_ready", 32'(a_cpu_req_ready), 0);
        nxt; a_dma(0, 0, 0, 0, 0);
        smp;
        chk("lone_cpu_ready", 32'(a_cpu_req_ready), 1);
        chk("lone_cpu_addr",  32'(a_dram_addr), 6);
        q_acpu.push_back('{t + 5, 32'h1000_0006});
        nxt; smp;
        chk("lone_cpu_hold", 32'(a_hold), 0);

        // ---------- A: CPU byte write and readback ----------
        nxt; a_cpu(1, 1, 32'h20, 32'h00AB_0000, 4'b0100); t = cyc;
        smp;
        chk("bw_ready",    32'(a_cpu_req_ready), 1);
        chk("bw_dram_we",  32'(a_dram_we), 32'h4);
        chk("bw_dram_wdi", a_dram_wdi, 32'h00AB_0000);
        chk("bw_addr",     32'(a_dram_addr), 8);
        q_acpu.push_back('{t + 1, 32'h0});
        nxt; smp;
        nxt; a_cpu(1, 0, 32'h20, 0, 4'hF);
        smp;
        chk("rb_ready", 32'(a_cpu_req_ready), 1);
        q_acpu.push_back('{t + 3, 32'h10AB_0008});
        nxt; smp;

        // ---------- A: DMA word write, readback with junk unused addr bits ----------
        nxt; a_cpu(0, 0, 0, 0, 0); a_dma(1, 1, 32'h24, 32'hCAFE_F00D, 4'hF); t = cyc;
        smp;
        chk("dw_ready",   32'(a_dma_req_ready), 1);
        chk("dw_dram_we", 32'(a_dram_we), 32'hF);
        chk("dw_hold",    32'(a_hold), 0);
        q_adma.push_back('{t + 1, 32'h0});
        nxt; smp;
        nxt; a_dma(1, 0, 32'hABCD_0027, 0, 4'h0);
        smp;
        chk("dr_addr", 32'(a_dram_addr), 9);
        q_adma.push_back('{t + 3, 32'hCAFE_F00D});
        nxt; smp;
        chk("dr_nonowner_cpu_rd", a_cpu_rsp_rdata, 0);
        nxt; a_dma(0, 0, 0, 0, 0);
        repeat (2) nxt;

        // ---------- B: RD_LAT=3 latency and next grant ----------
        b_cpu(1, 0, 32'h10, 0, 4'hF); t = cyc;
        smp;
        chk("l3_ready", 32'(b_cpu_req_ready), 1);
        chk("l3_en",    32'(b_dram_en), 1);
        chk("l3_addr",  32'(b_dram_addr), 4);
        q_bcpu.push_back('{t + 3, 32'hDEAD_BEEF});
        nxt; smp;
        chk("l3_t1_ready", 32'(b_cpu_req_ready), 0);
        chk("l3_t1_en",    32'(b_dram_en), 0);
        chk("l3_t1_hold",  32'(b_hold), 1);
        nxt; smp;
        chk("l3_t2_hold", 32'(b_hold), 1);
        nxt; smp;
        chk("l3_t3_ready", 32'(b_cpu_req_ready), 0);
        chk("l3_t3_hold",  32'(b_hold), 0);
        nxt; b_cpu(1, 0, 32'h14, 0, 4'hF);
        smp;
        chk("l3_t4_ready", 32'(b_cpu_req_ready), 1);
        q_bcpu.push_back('{t + 7, 32'h1000_0005});
        repeat (3) nxt;
        smp;
        chk("l3_t7_hold", 32'(b_hold), 0);

        // ---------- B: CPU priority against continuous DMA ----------
        nxt; b_cpu(1, 0, 32'h18, 0, 4'hF); b_dma(1, 0, 32'h1C, 0, 4'hF); t = cyc;
        smp;
        chk("pr1_cpu_ready", 32'(b_cpu_req_ready), 1);
        chk("pr1_dma_ready", 32'(b_dma_req_ready), 0);
        q_bcpu.push_back('{t + 3, 32'h1000_0006});
        repeat (3) nxt;
        smp;
        chk("pr1_dma_ready_rsp", 32'(b_dma_req_ready), 0);
        chk("pr1_nonowner_dma_rd", b_dma_rsp_rdata, 0);
        nxt; b_cpu(1, 0, 32'h10, 0, 4'hF);
        smp;
        chk("pr2_cpu_ready", 32'(b_cpu_req_ready), 1);
        chk("pr2_dma_ready", 32'(b_dma_req_ready), 0);
        q_bcpu.push_back('{t + 7, 32'hDEAD_BEEF});
        repeat (3) nxt;
        nxt; b_cpu(0, 0, 0, 0, 0);
        smp;
        chk("pr3_dma_ready", 32'(b_dma_req_ready), 1);
        chk("pr3_hold",      32'(b_hold), 0);
        q_bdma.push_back('{t + 11, 32'h1000_0007});
        repeat (3) nxt;
        nxt; b_dma(0, 0, 0, 0, 0);
        nxt;

        // ---------- B: reset while BUSY drops the transaction ----------
        b_cpu(1, 0, 32'h10, 0, 4'hF); t = cyc;
        smp;
        chk("rb3_ready", 32'(b_cpu_req_ready), 1);
        nxt; rst = 1'b1;
        smp;
        chk("rb3_rst_rsp",  32'(b_cpu_rsp_valid), 0);
        chk("rb3_rst_hold", 32'(b_hold), 1);
        chk("rb3_rst_en",   32'(b_dram_en), 0);
        nxt; rst = 1'b0; b_cpu(0, 0, 0, 0, 0);
        smp;
        nxt; b_cpu(1, 0, 32'h14, 0, 4'hF);
        smp;
        chk("rb3_new_ready", 32'(b_cpu_req_ready), 1);
        q_bcpu.push_back('{t + 6, 32'h1000_0005});
        repeat (3) nxt;
        nxt; b_cpu(0, 0, 0, 0, 0);
        repeat (4) nxt;
        smp;

        chk("a_cpu_missing_rsp", 32'(q_acpu.size()), 0);
        chk("a_dma_missing_rsp", 32'(q_adma.size()), 0);
        chk("b_cpu_missing_rsp", 32'(q_bcpu.size()), 0);
        chk("b_dma_missing_rsp", 32'(q_bdma.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
